rd_ctrl_n2one: RTL
==================

Name: rd_ctrl_n2one

Overview:
- Read-side controller for the many-to-one async FIFO. It sits downstream of the write controller and consumes that block's binary write pointer, which only advances when a full word has been assembled.
- It synchronises the write pointer into the read domain, generates the empty flag and the read pointer, and drives the FIFO memory read port.
- It presents words on a first-word-fall-through valid/ready interface through a 2-entry output buffer.
- o_rd_ptr feeds the write controller's i_rd_ptr input.

Parameters:
- P_PTR_MSB, 4, MSB of the read and write pointers. Pointers wrap modulo 2^(P_PTR_MSB+1); usable capacity is 2^(P_PTR_MSB+1)-1 words.
- P_DATA_MSB, 31, MSB of the memory word and of o_data.
- P_SYNC_STAGES, 2, number of flops in the write-pointer synchroniser chain. Minimum 2.

Ports:
- i_clk  in  1  read-domain clock.
- i_rst  in  1  reset, synchronous, active-high; clock i_clk.
- i_wr_ptr  in  P_PTR_MSB+1  binary write pointer from the write domain; not grey-coded.
- o_empty  out  1  high when no unread words remain in memory.
- o_rd_ptr  out  P_PTR_MSB+1  read pointer, returned to the write controller.
- o_mem_rd_en  out  1  memory read strobe.
- o_mem_addr  out  P_PTR_MSB+1  memory read address.
- i_mem_data  in  P_DATA_MSB+1  memory read data, valid 1 cycle after o_mem_rd_en.
- o_data  out  P_DATA_MSB+1  head word of the output buffer.
- o_valid  out  1  o_data holds a valid word.
- i_ready  in  1  consumer accepts o_data.

Behaviour:
- Reset: all sync flops 0, r_wptr_s 0, r_rd_ptr 0, r_inflight 0, buffer count 0. Outputs: o_empty=1, o_valid=0, o_data=0, o_mem_rd_en=0, o_mem_addr=0, o_rd_ptr=0.
- Reset mid-operation discards buffered and in-flight words. The write side must be reset in the same window.
- Synchroniser: i_wr_ptr passes through P_SYNC_STAGES flops; the last stage is w_sync.
- Stability filter: r_samp <= w_sync every cycle. r_wptr_s <= w_sync only when w_sync == r_samp; otherwise r_wptr_s holds. This rejects torn binary samples.
- Latency from a stable i_wr_ptr change to r_wptr_s update: P_SYNC_STAGES+1 cycles.
- Empty: w_empty = (r_rd_ptr == r_wptr_s), taken from registers only. o_empty = w_empty.
- Occupancy: buffer count r_cnt is 0..2. pop = o_valid & i_ready.
- Issue condition: issue = ~w_empty & ((r_cnt + r_inflight - pop) < 2).
- On issue, in the same cycle: o_mem_rd_en=1, o_mem_addr=r_rd_ptr. At the clock edge: r_rd_ptr <= r_rd_ptr+1 with native wrap, and r_inflight <= 1.
- No issue: o_mem_rd_en=0, r_inflight <= 0. o_mem_addr holds r_rd_ptr; it is don't-care when o_mem_rd_en=0.
- Capture: when r_inflight=1, i_mem_data is written to the buffer tail at the edge.
- Simultaneous capture and pop: r_cnt unchanged, FIFO order preserved.
- Latency: empty->non-empty seen in cycle T; o_mem_rd_en in T; data captured at the end of T+1; o_valid high in T+2.
- Throughput: 1 word/cycle is sustained while i_ready=1 and data is available.
- o_valid = (r_cnt != 0); o_data = buffer head.
- While o_valid & ~i_ready, o_data and o_valid hold stable.
- Backpressure: with r_cnt=2, or r_cnt=1 with r_inflight=1, and no pop, no issue occurs.
- Wrap: pointer compare is over the full P_PTR_MSB+1 bits. FIFO full (wr = rd-1) is handled by the write side only; this block only drains.
- o_rd_ptr advances at issue time. The addressed slot has already been read by the time the writer observes the new pointer.
- A write-pointer jump of more than 1 (multiple words committed) is legal. All words up to r_wptr_s are read in order.

Test Plan:
- Reset: hold i_rst 3 cycles with i_wr_ptr=7 -> o_empty=1, o_valid=0, o_rd_ptr=0, o_mem_rd_en=0 throughout. The first o_mem_rd_en occurs no earlier than P_SYNC_STAGES+1 cycles after release.
- Basic drain: i_wr_ptr 0->3 held stable, i_ready=1, memory preloaded D0..D2 -> o_mem_rd_en high 3 consecutive cycles at addresses 0,1,2. o_valid high 3 consecutive cycles with D0,D1,D2. Final o_rd_ptr=3, o_empty=1.
- Backpressure: i_wr_ptr=5, i_ready=0 -> exactly 2 reads (addresses 0,1), o_data=D0 stable, o_valid=1. Raising i_ready -> D0..D4 in order, no drops or duplicates, o_rd_ptr=5.
- Wrap: P_PTR_MSB=4, pointers at 30 after prior traffic, i_wr_ptr set to 2 -> reads at addresses 30,31,0,1. o_empty=1 with o_rd_ptr=2.
- Unstable pointer: i_wr_ptr toggles 4<->7 every cycle -> r_wptr_s does not change and no reads beyond address 3. Holding 7 stable -> addresses 4,5,6 are read.
- Mid-stream reset: assert i_rst when r_cnt=2 and r_inflight=1 -> after that edge o_valid=0, o_empty=1, o_rd_ptr=0. Captured data is not presented after reset.

Source files
------------

// File: rtl/rd_ctrl_n2one_if.sv
// ---------------------------------------------------------------------------
// rd_ctrl_n2one_if
// Bundles the read-side controller's pointer exchange, memory read port and
// output stream so they travel as one port.
//
// Signals:
//   i_wr_ptr    write pointer from the write domain (binary, unsynchronised)
//   o_empty     no unread words left in memory
//   o_rd_ptr    read pointer returned to the write controller
//   o_mem_rd_en memory read strobe
//   o_mem_addr  memory read address
//   i_mem_data  memory read data, valid one cycle after o_mem_rd_en
//   o_data      head word of the output buffer
//   o_valid     o_data holds a valid word
//   i_ready     consumer accepts o_data
//
// Output handshake: a word transfers in any cycle where o_valid & i_ready is
// high at the clock edge. Once o_valid is raised, o_valid and o_data stay
// stable until that transfer happens; i_ready may be raised or dropped freely.
//
// Modports: master = the read controller, slave = its surroundings.
// ---------------------------------------------------------------------------
interface rd_ctrl_n2one_if #(
    parameter int P_PTR_MSB  = 4,
    parameter int P_DATA_MSB = 31
);
    logic [P_PTR_MSB:0]  i_wr_ptr;
    logic                o_empty;
    logic [P_PTR_MSB:0]  o_rd_ptr;
    logic                o_mem_rd_en;
    logic [P_PTR_MSB:0]  o_mem_addr;
    logic [P_DATA_MSB:0] i_mem_data;
    logic [P_DATA_MSB:0] o_data;
    logic                o_valid;
    logic                i_ready;

    modport master (
        input  i_wr_ptr,
        input  i_mem_data,
        input  i_ready,
        output o_empty,
        output o_rd_ptr,
        output o_mem_rd_en,
        output o_mem_addr,
        output o_data,
        output o_valid
    );

    modport slave (
        output i_wr_ptr,
        output i_mem_data,
        output i_ready,
        input  o_empty,
        input  o_rd_ptr,
        input  o_mem_rd_en,
        input  o_mem_addr,
        input  o_data,
        input  o_valid
    );
endinterface

// File: rtl/rd_ctrl_n2one.sv
// ---------------------------------------------------------------------------
// rd_ctrl_n2one
// Read-side controller of the many-to-one async FIFO. Synchronises the
// binary write pointer into the read clock domain, filters torn samples,
// generates empty and the read pointer, drives the memory read port and
// presents words first-word-fall-through through a 2-entry output buffer.
//
// Ports:
//   i_clk  read-domain clock
//   i_rst  synchronous active-high reset
//   bus    rd_ctrl_n2one_if.master (pointer exchange, memory port, stream)
//
// Parameters:
//   P_PTR_MSB      MSB of the pointers (wrap modulo 2^(P_PTR_MSB+1))
//   P_DATA_MSB     MSB of the memory word
//   P_SYNC_STAGES  synchroniser depth, at least 2
// ---------------------------------------------------------------------------
module rd_ctrl_n2one #(
    parameter int P_PTR_MSB     = 4,
    parameter int P_DATA_MSB    = 31,
    parameter int P_SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    rd_ctrl_n2one_if.master   bus
);

    // ---------------------------------------------------------------
    // Write-pointer synchroniser and stability filter
    // ---------------------------------------------------------------
    logic [P_PTR_MSB:0] r_sync [P_SYNC_STAGES];
    logic [P_PTR_MSB:0] w_sync;
    logic [P_PTR_MSB:0] r_samp;
    logic [P_PTR_MSB:0] r_wptr_s;

    assign w_sync = r_sync[P_SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < P_SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= bus.i_wr_ptr;
            for (int i = 1; i < P_SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // The pointer is binary, so several bits may change at once and a
    // sample can be torn. Only a value seen on two consecutive cycles is
    // trusted; anything else leaves the last trusted pointer in place.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_samp   <= '0;
            r_wptr_s <= '0;
        end else begin
            r_samp <= w_sync;
            if (w_sync == r_samp) begin
                r_wptr_s <= w_sync;
            end
        end
    end

    // ---------------------------------------------------------------
    // Read issue
    // ---------------------------------------------------------------
    logic [P_PTR_MSB:0]  r_rd_ptr;
    logic                r_inflight;
    logic [1:0]          r_cnt;
    logic                r_head;
    logic [P_DATA_MSB:0] r_buf [2];

    logic                w_empty;
    logic                w_pop;
    logic                w_valid;
    logic [2:0]          w_slots;
    logic                w_issue;
    logic                w_tail;

    assign w_empty = (r_rd_ptr == r_wptr_s);
    assign w_valid = (r_cnt != 2'd0);
    assign w_pop   = w_valid & bus.i_ready;

    // Slots that will be committed after this edge: buffered words plus
    // the word returning from memory, minus the one leaving. Counting the
    // pop lets the buffer refill in the same cycle it drains, which is
    // what sustains one word per cycle.
    assign w_slots = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = ~w_empty & (w_slots < 3'd2);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Two-entry output buffer (circular, head index + count)
    // ---------------------------------------------------------------
    // Tail is computed from the pre-pop head, so a simultaneous capture
    // and pop writes behind the word being removed and order is kept.
    assign w_tail = r_head ^ r_cnt[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= 2'd0;
            r_head <= 1'b0;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else begin
            if (r_inflight) begin
                r_buf[w_tail] <= bus.i_mem_data;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign bus.o_empty     = w_empty;
    assign bus.o_rd_ptr    = r_rd_ptr;
    assign bus.o_mem_rd_en = w_issue;
    assign bus.o_mem_addr  = r_rd_ptr;
    assign bus.o_valid     = w_valid;
    assign bus.o_data      = r_buf[r_head];

endmodule
